// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_pkg;

    typedef enum logic {
        SCAN_GAP  = 1'b0,
        SCAN_SHOW = 1'b1
    } scan_state_t;

    localparam int MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    localparam int DEF_SLOT_CYCLES = 100000;
    localparam int DEF_GAP_CYCLES  = 1000;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter, GAP/SHOW state and digit index for the scan driver.
// Exposes next-cycle state so the top can register its outputs without lag.
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int IDX_W       = idx_width(DIGITS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_show_nxt,
    output logic [IDX_W-1:0] o_idx_nxt,
    output logic             o_frame_end,
    output logic             o_frame_end_nxt
);

    localparam int CNT_W = idx_width(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_slot_end;

    always_comb begin
        w_slot_end  = (r_cnt == SLOT_LAST);
        w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_slot_end) begin
            w_state_nxt = SCAN_GAP;
            w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else if (r_cnt == GAP_LAST) begin
            w_state_nxt = SCAN_SHOW;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SCAN_GAP;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign o_show_nxt      = (w_state_nxt == SCAN_SHOW);
    assign o_idx_nxt       = w_idx_nxt;
    assign o_frame_end     = w_slot_end && (r_idx == IDX_LAST);
    assign o_frame_end_nxt = (w_cnt_nxt == SLOT_LAST) && (w_idx_nxt == IDX_LAST);

endmodule

// File: rtl/seg_scan_driver.sv
// Double-buffered, dead-time-gapped scan driver for a common-anode 7-seg bank.
// Define SEG_SCAN_ZERO_BLANK_EN to blank leading-zero digits of the active value.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [4*DIGITS-1:0]        Value,
    input  logic [DIGITS-1:0]          Dp_Mask,
    input  logic [DIGITS-1:0]          Digit_En,
    input  logic                       Load,
    output logic [3:0]                 Bin,
    output logic                       Dp_n,
    output logic [DIGITS-1:0]          Anode,
    output logic [$clog2(DIGITS)-1:0]  Digit_Idx,
    output logic                       Frame_Done
);

    localparam int IDX_W = $clog2(DIGITS);

    logic [4*DIGITS-1:0] r_sh_val;
    logic [DIGITS-1:0]   r_sh_dp;
    logic [DIGITS-1:0]   r_sh_en;
    logic [4*DIGITS-1:0] r_act_val;
    logic [DIGITS-1:0]   r_act_dp;
    logic [DIGITS-1:0]   r_act_en;

    logic [4*DIGITS-1:0] w_act_val_nxt;
    logic [DIGITS-1:0]   w_act_dp_nxt;
    logic [DIGITS-1:0]   w_act_en_nxt;
    logic [DIGITS-1:0]   w_en_eff;
    logic                w_show_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_frame_end;
    logic                w_frame_end_nxt;
    logic                w_lit;

    seg_slot_timer #(
        .DIGITS      (DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .IDX_W       (IDX_W)
    ) u_timer (
        .i_clk           (Clk),
        .i_rst_n         (Reset_n),
        .o_show_nxt      (w_show_nxt),
        .o_idx_nxt       (w_idx_nxt),
        .o_frame_end     (w_frame_end),
        .o_frame_end_nxt (w_frame_end_nxt)
    );

    // Outputs are registered from next-cycle values, so the active buffer they see
    // must already include the copy made at the frame boundary.
    always_comb begin
        w_act_val_nxt = w_frame_end ? r_sh_val : r_act_val;
        w_act_dp_nxt  = w_frame_end ? r_sh_dp  : r_act_dp;
        w_act_en_nxt  = w_frame_end ? r_sh_en  : r_act_en;
    end

`ifdef SEG_SCAN_ZERO_BLANK_EN
    // Digit k stays lit only if it or some higher digit is nonzero; digit 0 always qualifies.
    function automatic logic [DIGITS-1:0] lead_mask(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] m;
        logic              seen;
        m    = '0;
        seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen = seen | (v[4*k +: 4] != 4'h0);
            m[k] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    assign w_en_eff = w_act_en_nxt & lead_mask(w_act_val_nxt);
`else
    assign w_en_eff = w_act_en_nxt;
`endif

    assign w_lit = w_show_nxt && w_en_eff[w_idx_nxt];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sh_val   <= '0;
            r_sh_dp    <= '0;
            r_sh_en    <= '0;
            r_act_val  <= '0;
            r_act_dp   <= '0;
            r_act_en   <= '0;
            Anode      <= ANODE_OFF[DIGITS-1:0];
            Dp_n       <= 1'b1;
            Bin        <= 4'h0;
            Digit_Idx  <= '0;
            Frame_Done <= 1'b0;
        end else begin
            if (Load) begin
                r_sh_val <= Value;
                r_sh_dp  <= Dp_Mask;
                r_sh_en  <= Digit_En;
            end
            r_act_val  <= w_act_val_nxt;
            r_act_dp   <= w_act_dp_nxt;
            r_act_en   <= w_act_en_nxt;
            Anode      <= w_lit ? ~(DIGITS'(1) << w_idx_nxt) : ANODE_OFF[DIGITS-1:0];
            Dp_n       <= ~(w_show_nxt & w_act_dp_nxt[w_idx_nxt]);
            Bin        <= w_act_val_nxt[{w_idx_nxt, 2'b00} +: 4];
            Digit_Idx  <= w_idx_nxt;
            Frame_Done <= w_frame_end_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with DIGITS=4, SLOT_CYCLES=8, GAP_CYCLES=2.
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int SLOT   = 8;
    localparam int GAP    = 2;
    localparam int FRAME  = DIGITS * SLOT;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] Value;
    logic [3:0]  Dp_Mask;
    logic [3:0]  Digit_En;
    logic        Load;
    logic [3:0]  Bin;
    logic        Dp_n;
    logic [3:0]  Anode;
    logic [1:0]  Digit_Idx;
    logic        Frame_Done;

    always #5 Clk = ~Clk;

    seg_scan_driver #(
        .DIGITS      (DIGITS),
        .SLOT_CYCLES (SLOT),
        .GAP_CYCLES  (GAP)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Value      (Value),
        .Dp_Mask    (Dp_Mask),
        .Digit_En   (Digit_En),
        .Load       (Load),
        .Bin        (Bin),
        .Dp_n       (Dp_n),
        .Anode      (Anode),
        .Digit_Idx  (Digit_Idx),
        .Frame_Done (Frame_Done)
    );

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [3:0] bin;
        logic       dpn;
        logic       fd;
        logic [1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   t        = 0;

    logic [15:0] m_sh_val, m_act_val;
    logic [3:0]  m_sh_dp, m_act_dp, m_sh_en, m_act_en;

`ifdef SEG_SCAN_ZERO_BLANK_EN
    function automatic logic [3:0] blank_mask(input logic [15:0] v);
        logic [3:0] m;
        for (int k = 0; k < DIGITS; k++) m[k] = (k == 0) || ((v >> (4 * k)) != 16'h0);
        return m;
    endfunction
`endif

    // Expected outputs for cycle tc, derived from the cycle number and the model's active buffer.
    function automatic exp_t model_out(input int tc);
        exp_t       e;
        int         slot;
        int         pos;
        logic       show;
        logic [3:0] en;
        slot = (tc / SLOT) % DIGITS;
        pos  = tc % SLOT;
        show = (pos >= GAP);
        en   = m_act_en;
`ifdef SEG_SCAN_ZERO_BLANK_EN
        en   = en & blank_mask(m_act_val);
`endif
        e.t   = tc;
        e.idx = 2'(slot);
        e.bin = m_act_val[slot*4 +: 4];
        e.an  = (show && en[slot]) ? ~(4'b0001 << slot) : 4'b1111;
        e.dpn = !(show && m_act_dp[slot]);
        e.fd  = ((tc % FRAME) == FRAME - 1);
        return e;
    endfunction

    task automatic chk(input string tag, input int tc, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, tc, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty t=%0d observed=0 expected=1", t);
            return;
        end
        e = sb.pop_front();
        chk("anode",      e.t, 8'(Anode),      8'(e.an));
        chk("bin",        e.t, 8'(Bin),        8'(e.bin));
        chk("dp_n",       e.t, 8'(Dp_n),       8'(e.dpn));
        chk("frame_done", e.t, 8'(Frame_Done), 8'(e.fd));
        chk("digit_idx",  e.t, 8'(Digit_Idx),  8'(e.idx));
    endtask

    // Drive one cycle of stimulus, predict the following cycle, then sample it.
    task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
        Load     = ld;
        Value    = v;
        Dp_Mask  = dp;
        Digit_En = en;
        if ((t % FRAME) == FRAME - 1) begin
            m_act_val = m_sh_val;
            m_act_dp  = m_sh_dp;
            m_act_en  = m_sh_en;
        end
        if (ld) begin
            m_sh_val = v;
            m_sh_dp  = dp;
            m_sh_en  = en;
        end
        sb.push_back(model_out(t + 1));
        @(posedge Clk);
        @(negedge Clk);
        t++;
        Load = 1'b0;
        check_out();
    endtask

    task automatic idle();
        cycle(1'b0, Value, Dp_Mask, Digit_En);
    endtask

    task automatic idle_to(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) idle();
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        Load    = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("rst_anode", 0, 8'(Anode),      8'hF);
        chk("rst_dp_n",  0, 8'(Dp_n),       8'h1);
        chk("rst_bin",   0, 8'(Bin),        8'h0);
        chk("rst_idx",   0, 8'(Digit_Idx),  8'h0);
        chk("rst_fd",    0, 8'(Frame_Done), 8'h0);
        @(negedge Clk);
        Reset_n   = 1'b1;
        t         = 0;
        m_sh_val  = '0; m_sh_dp  = '0; m_sh_en  = '0;
        m_act_val = '0; m_act_dp = '0; m_act_en = '0;
        sb.delete();
        sb.push_back(model_out(0));
        check_out();
    endtask

    initial begin
        Reset_n  = 1'b0;
        Load     = 1'b0;
        Value    = '0;
        Dp_Mask  = '0;
        Digit_En = '0;
        do_reset();

        cycle(1'b1, 16'h1234, 4'b0000, 4'hF);
        repeat (2 * FRAME) idle();

        cycle(1'b1, 16'h1234, 4'b0010, 4'b0101);
        repeat (2 * FRAME) idle();

        cycle(1'b1, 16'h1234, 4'b0010, 4'hF);
        repeat (FRAME) idle();

        // Load landing exactly on the frame-boundary cycle
        idle_to(FRAME - 1);
        cycle(1'b1, 16'h5678, 4'b1000, 4'hF);
        repeat (2 * FRAME) idle();

        // Two loads inside one frame; the later one must win
        idle_to(10);
        cycle(1'b1, 16'hAAAA, 4'b0000, 4'hF);
        idle();
        cycle(1'b1, 16'hBBBB, 4'b0000, 4'hF);
        repeat (2 * FRAME) idle();

        cycle(1'b1, 16'h0045, 4'b0000, 4'hF);
        repeat (2 * FRAME) idle();
        cycle(1'b1, 16'h0000, 4'b0000, 4'hF);
        repeat (2 * FRAME) idle();

        // Asynchronous reset in the middle of digit 2's SHOW window
        cycle(1'b1, 16'h9ABC, 4'b0100, 4'hF);
        repeat (FRAME + 4) idle();
        idle_to(20);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_anode", t, 8'(Anode),     8'hF);
        chk("async_rst_idx",   t, 8'(Digit_Idx), 8'h0);
        chk("async_rst_bin",   t, 8'(Bin),       8'h0);
        chk("async_rst_dp_n",  t, 8'(Dp_n),      8'h1);
        do_reset();
        cycle(1'b1, 16'hC0DE, 4'b0001, 4'hF);
        repeat (2 * FRAME) idle();

        chk("scoreboard_drained", t, 8'(sb.size()), 8'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
